// File: rtl/vector_core_p_if.sv
// Instruction handshake and retire strobe between an instruction source and vector_core_p.
interface vector_core_p_if #(
   parameter int IW = 17
);
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic          instr_ready;
   logic          done;

   modport master (output instr, output instr_valid, input instr_ready, input done);
   modport slave  (input instr, input instr_valid, output instr_ready, output done);
endinterface

// File: rtl/vector_core_p.sv
// Instruction-driven vector core: NREG-entry register file, MEM_DEPTH-entry vector memory,
// LANES-wide unsigned add/multiply, sequenced IDLE -> READ -> EXEC -> WRITE.
module vector_core_p #(
   parameter int LANES     = 16,
   parameter int EW        = 32,
   parameter int NREG      = 4,
   parameter int MEM_DEPTH = 512
) (
   input  logic                            clk,
   input  logic                            reset,
   vector_core_p_if.slave                  cpu,
   input  logic                            host_wr_en,
   input  logic [$clog2(MEM_DEPTH)-1:0]    host_wr_addr,
   input  logic [LANES*EW-1:0]             host_wr_data,
   output logic [NREG*LANES*EW-1:0]        rf_flat
);
   localparam int RW = $clog2(NREG);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam int IW = 2 + 3*RW + AW;
   localparam int VW = LANES*EW;

   typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_ADD, OP_MUL} op_e;
   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_e;

   // Full-width unsigned lane result; for ADD the upper half is the carry.
   function automatic logic [2*EW-1:0] lane_op(input op_e op, input logic [EW-1:0] a,
                                               input logic [EW-1:0] b);
      logic [2*EW-1:0] wa;
      logic [2*EW-1:0] wb;
      wa = {{EW{1'b0}}, a};
      wb = {{EW{1'b0}}, b};
      if (op == OP_MUL) lane_op = wa * wb;
      else              lane_op = wa + wb;
   endfunction

   state_e          state, state_nx;
   logic            accept, host_ok, rf_we, mem_st, hi_we;
   logic            mem_we;
   logic [AW-1:0]   mem_wa;
   logic [VW-1:0]   mem_wd;

   logic [IW-1:0]   ir_p0;
   op_e             op_p0;
   logic [RW-1:0]   rd_p0, rd_hi_p0, rs_p0, rt_p0;
   logic [AW-1:0]   addr_p0;

   logic [VW-1:0]   rf  [NREG];
   logic [VW-1:0]   mem [MEM_DEPTH];
   logic [VW-1:0]   opa_p1, opb_p1, mem_q_p1;
   logic [VW-1:0]   alu_lo, alu_hi;
   logic [VW-1:0]   lo_p2, hi_p2;

   assign op_p0    = op_e'(ir_p0[IW-1 -: 2]);
   assign rd_p0    = ir_p0[AW+3*RW-1 -: RW];
   assign rs_p0    = ir_p0[AW+2*RW-1 -: RW];
   assign rt_p0    = ir_p0[AW+RW-1 -: RW];
   assign addr_p0  = ir_p0[AW-1:0];
   assign rd_hi_p0 = rd_p0 + 1'b1;
   assign hi_we    = (op_p0 == OP_ADD) || (op_p0 == OP_MUL);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Reset gates every side effect so an instruction caught mid-flight leaves no trace.
   always_comb begin
      state_nx        = state;
      cpu.instr_ready = 1'b0;
      cpu.done        = 1'b0;
      accept          = 1'b0;
      host_ok         = 1'b0;
      rf_we           = 1'b0;
      mem_st          = 1'b0;
      case (state)
         S_IDLE: begin
            cpu.instr_ready = 1'b1;
            accept          = cpu.instr_valid && !reset;
            host_ok         = host_wr_en && !accept && !reset;
            if (cpu.instr_valid) state_nx = S_READ;
         end
         S_READ:  state_nx = S_EXEC;
         S_EXEC:  state_nx = S_WRITE;
         S_WRITE: begin
            state_nx = S_IDLE;
            cpu.done = !reset;
            rf_we    = !reset && (op_p0 != OP_STORE);
            mem_st   = !reset && (op_p0 == OP_STORE);
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Stage p0: instruction latch
   always_ff @(posedge clk) begin
      if (reset)       ir_p0 <= '0;
      else if (accept) ir_p0 <= cpu.instr;
   end

   // Stage p1: operand capture and synchronous memory read
   always_ff @(posedge clk) begin
      if (state == S_READ) begin
         opa_p1 <= rf[rs_p0];
         opb_p1 <= rf[rt_p0];
      end
   end

   assign mem_we = host_ok || mem_st;
   assign mem_wa = mem_st ? addr_p0 : host_wr_addr;
   assign mem_wd = mem_st ? opa_p1  : host_wr_data;

   always_ff @(posedge clk) begin
      if (mem_we)          mem[mem_wa] <= mem_wd;
      if (state == S_READ) mem_q_p1    <= mem[addr_p0];
   end

   always_comb begin
      alu_lo = '0;
      alu_hi = '0;
      for (int i = 0; i < LANES; i++) begin
         {alu_hi[i*EW +: EW], alu_lo[i*EW +: EW]} =
            lane_op(op_p0, opa_p1[i*EW +: EW], opb_p1[i*EW +: EW]);
      end
   end

   // Stage p2: result register (ALU halves or loaded vector)
   always_ff @(posedge clk) begin
      if (state == S_EXEC) begin
         lo_p2 <= (op_p0 == OP_LOAD) ? mem_q_p1 : alu_lo;
         hi_p2 <= alu_hi;
      end
   end

   // Commit: low half to rd, high half to rd+1 (wrapping), both in the same cycle
   always_ff @(posedge clk) begin
      for (int r = 0; r < NREG; r++) begin
         if (reset)                                    rf[r] <= '0;
         else if (rf_we && RW'(r) == rd_p0)            rf[r] <= lo_p2;
         else if (rf_we && hi_we && RW'(r) == rd_hi_p0) rf[r] <= hi_p2;
      end
   end

   for (genvar r = 0; r < NREG; r++) begin : g_flat
      assign rf_flat[r*VW +: VW] = rf[r];
   end
endmodule

// File: tb/tb_vector_core_p.sv
// Scoreboard bench for vector_core_p: directed scenarios plus randomized instruction streams.
module tb_vector_core_p;
   localparam int LANES = 16, EW = 32, NREG = 4, MEM_DEPTH = 512;
   localparam int RW = 2, AW = 9, IW = 2 + 3*RW + AW, VW = LANES*EW;
   localparam logic [1:0] LOAD = 2'd0, STORE = 2'd1, ADD = 2'd2, MUL = 2'd3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic host_wr_en = 1'b0;
   logic [AW-1:0] host_wr_addr = '0;
   logic [VW-1:0] host_wr_data = '0;
   logic [NREG*VW-1:0] rf_flat;

   vector_core_p_if #(.IW(IW)) bus ();

   vector_core_p #(.LANES(LANES), .EW(EW), .NREG(NREG), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk(clk), .reset(reset), .cpu(bus), .host_wr_en(host_wr_en),
      .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .rf_flat(rf_flat));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Reference state: registers and memory as arrays of lane words
   logic [EW-1:0] mreg [NREG][LANES];
   logic [EW-1:0] mmem [MEM_DEPTH][LANES];
   logic [NREG*VW-1:0] exp_q[$];
   int acc_q[$];
   int pending = 0;
   int checks = 0, errors = 0;

   function automatic logic [NREG*VW-1:0] model_flat();
      logic [NREG*VW-1:0] v;
      for (int r = 0; r < NREG; r++)
         for (int i = 0; i < LANES; i++) v[(r*LANES+i)*EW +: EW] = mreg[r][i];
      return v;
   endfunction

   function automatic void model_exec(input logic [1:0] op, input int rd, input int rs,
                                      input int rt, input int addr);
      logic [EW-1:0] lo [LANES];
      logic [EW-1:0] hi [LANES];
      logic [63:0] a, b, p;
      if (op == LOAD) begin
         for (int i = 0; i < LANES; i++) mreg[rd][i] = mmem[addr][i];
      end else if (op == STORE) begin
         for (int i = 0; i < LANES; i++) mmem[addr][i] = mreg[rs][i];
      end else begin
         for (int i = 0; i < LANES; i++) begin
            a = 64'(mreg[rs][i]);
            b = 64'(mreg[rt][i]);
            p = (op == ADD) ? a + b : a * b;
            lo[i] = p[31:0];
            hi[i] = p[63:32];
         end
         for (int i = 0; i < LANES; i++) begin
            mreg[rd][i] = lo[i];
            mreg[(rd+1) % NREG][i] = hi[i];
         end
      end
   endfunction

   function automatic logic [VW-1:0] ramp(input int base, input int step);
      logic [VW-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*EW +: EW] = 32'(base + i*step);
      return v;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*EW +: EW] = $urandom;
      return v;
   endfunction

   task automatic check_rf(input string name, input logic [NREG*VW-1:0] exp);
      checks++;
      if (rf_flat !== exp) begin
         errors++;
         for (int k = 0; k < NREG*LANES; k++) begin
            if (rf_flat[k*EW +: EW] !== exp[k*EW +: EW]) begin
               $display("FAIL %s reg%0d lane%0d got %h expected %h", name, k/LANES, k%LANES,
                        rf_flat[k*EW +: EW], exp[k*EW +: EW]);
               break;
            end
         end
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b", name, got, exp);
      end
   endtask

   task automatic check_lane(input string name, input int r, input int lane, input logic [EW-1:0] exp);
      logic [EW-1:0] got;
      got = rf_flat[(r*LANES+lane)*EW +: EW];
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s reg%0d lane%0d got %h expected %h", name, r, lane, got, exp);
      end
   endtask

   // Monitor: every done pops one expectation; state is compared after the commit edge
   logic [NREG*VW-1:0] mon_exp;
   int mon_acc;
   always @(negedge clk) begin
      if (!reset && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_done at cycle %0d", cyc);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_acc = acc_q.pop_front();
            checks++;
            if (cyc - mon_acc != 2) begin
               errors++;
               $display("FAIL done_latency got %0d edges expected 2", cyc - mon_acc);
            end
            @(posedge clk); #1;
            check_rf("retire", mon_exp);
            pending--;
         end
      end
   end

   task automatic issue(input logic [1:0] op, input int rd, input int rs, input int rt,
                        input int addr, input bit commit, output int acc);
      bit rdy, got;
      got = 1'b0;
      acc = -1;
      @(negedge clk);
      bus.instr = {op, rd[RW-1:0], rs[RW-1:0], rt[RW-1:0], addr[AW-1:0]};
      bus.instr_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         rdy = bus.instr_ready;
         @(posedge clk); #1;
         if (rdy) begin got = 1'b1; break; end
         @(negedge clk);
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL accept_timeout op %0d", op);
      end else begin
         acc = cyc;
         if (commit) begin
            model_exec(op, rd, rs, rt, addr);
            exp_q.push_back(model_flat());
            acc_q.push_back(cyc);
            pending++;
         end
      end
   endtask

   task automatic wait_idle();
      @(negedge clk);
      bus.instr_valid = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (pending == 0 && bus.instr_ready) return;
         @(negedge clk);
      end
      checks++; errors++;
      $display("FAIL idle_timeout pending %0d ready %0b", pending, bus.instr_ready);
   endtask

   task automatic host_write(input int addr, input logic [VW-1:0] v, input bit honored);
      @(negedge clk);
      host_wr_en = 1'b1;
      host_wr_addr = addr[AW-1:0];
      host_wr_data = v;
      @(negedge clk);
      host_wr_en = 1'b0;
      if (honored)
         for (int i = 0; i < LANES; i++) mmem[addr][i] = v[i*EW +: EW];
   endtask

   task automatic reset_mid(input logic [1:0] op, input int rd, input int rs, input int rt,
                            input int addr, input int nedges);
      int acc;
      issue(op, rd, rs, rt, addr, 1'b0, acc);
      repeat (nedges) @(posedge clk);
      #1;
      reset = 1'b1;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus.instr_valid = 1'b0;
      for (int r = 0; r < NREG; r++)
         for (int i = 0; i < LANES; i++) mreg[r][i] = '0;
      check_bit("ready_after_reset", bus.instr_ready, 1'b1);
      repeat (6) @(negedge clk);
      check_rf("reset_mid_rf", model_flat());
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int acc, last, op, rd, rs, rt, addr;
      for (int r = 0; r < NREG; r++)
         for (int i = 0; i < LANES; i++) mreg[r][i] = '0;
      for (int a = 0; a < MEM_DEPTH; a++)
         for (int i = 0; i < LANES; i++) mmem[a][i] = '0;

      // Instruction presented while reset is held must be ignored
      bus.instr = {LOAD, 2'd0, 2'd0, 2'd0, 9'd5};
      bus.instr_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus.instr_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_rf("reset_rf", '0);
         check_bit("reset_done", bus.done, 1'b0);
         check_bit("reset_ready", bus.instr_ready, 1'b1);
      end

      host_write(5, ramp(1, 1), 1'b1);
      issue(LOAD, 0, 0, 0, 5, 1'b1, acc);
      wait_idle();
      check_lane("load_lane0", 0, 0, 32'd1);
      check_lane("load_lane15", 0, 15, 32'd16);

      host_write(6, ramp(-1, 0), 1'b1);
      host_write(7, ramp(2, 0), 1'b1);
      issue(LOAD, 0, 0, 0, 6, 1'b1, acc);
      issue(LOAD, 1, 0, 0, 7, 1'b1, acc);
      issue(ADD, 2, 0, 1, 0, 1'b1, acc);
      wait_idle();
      check_lane("add_lo", 2, 0, 32'h1);
      check_lane("add_carry", 3, 7, 32'h1);
      issue(MUL, 3, 0, 0, 0, 1'b1, acc);
      wait_idle();
      check_lane("mul_lo", 3, 0, 32'h1);
      check_lane("mul_hi_wrap", 0, 5, 32'hFFFF_FFFE);

      issue(STORE, 0, 2, 0, 511, 1'b1, acc);
      issue(LOAD, 1, 0, 0, 511, 1'b1, acc);
      wait_idle();
      check_lane("store_load", 1, 9, 32'h1);

      // Host write while the core is in READ is dropped
      issue(ADD, 2, 0, 1, 0, 1'b1, acc);
      host_write(6, ramp(32'h55, 0), 1'b0);
      wait_idle();
      issue(LOAD, 3, 0, 0, 6, 1'b1, acc);
      wait_idle();
      check_lane("host_drop", 3, 2, 32'hFFFF_FFFF);

      // Continuous valid: accepts spaced exactly four edges apart
      issue(LOAD, 2, 0, 0, 7, 1'b1, last);
      issue(ADD, 0, 1, 2, 0, 1'b1, acc);
      check_bit("stream_gap1", (acc - last) == 4, 1'b1); last = acc;
      issue(MUL, 1, 0, 0, 0, 1'b1, acc);
      check_bit("stream_gap2", (acc - last) == 4, 1'b1); last = acc;
      issue(STORE, 0, 1, 0, 10, 1'b1, acc);
      check_bit("stream_gap3", (acc - last) == 4, 1'b1);
      wait_idle();

      host_write(8, ramp(3, 0), 1'b1);
      host_write(9, ramp(5, 0), 1'b1);
      issue(LOAD, 0, 0, 0, 8, 1'b1, acc);
      issue(LOAD, 1, 0, 0, 9, 1'b1, acc);
      issue(MUL, 0, 0, 1, 0, 1'b1, acc);
      wait_idle();
      check_lane("alias_lo", 0, 0, 32'd15);
      check_lane("alias_hi", 1, 0, 32'd0);

      reset_mid(MUL, 2, 0, 1, 0, 1);
      host_write(12, ramp(7, 1), 1'b1);
      reset_mid(STORE, 0, 0, 0, 12, 2);
      issue(LOAD, 0, 0, 0, 12, 1'b1, acc);
      wait_idle();
      check_lane("store_abandoned", 0, 4, 32'd11);

      for (int a = 16; a < 24; a++) host_write(a, rand_vec(), 1'b1);
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) < 3) begin
            wait_idle();
            if ($urandom_range(0, 1) == 1) host_write(16 + $urandom_range(0, 7), rand_vec(), 1'b1);
         end
         op   = $urandom_range(0, 3);
         rd   = $urandom_range(0, NREG-1);
         rs   = $urandom_range(0, NREG-1);
         rt   = $urandom_range(0, NREG-1);
         addr = 16 + $urandom_range(0, 7);
         issue(op[1:0], rd, rs, rt, addr, 1'b1, acc);
      end
      wait_idle();
      check_rf("final_rf", model_flat());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
